// File: rtl/core_time_counter.sv
// Stopwatch core: divides clk down to a TICK_HZ tick and accumulates hundredths on binary_time.
// Define CORE_TIME_COUNTDOWN_EN to add load/countdown with an expired pulse.
module core_time_counter #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int MAX_COUNT = 131071
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    input  logic        load,
    input  logic [16:0] load_value,
    output logic [16:0] binary_time,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic        expired
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_M1  = PW'(DIV - 1);
    localparam logic [16:0]   MAX_VAL = 17'(MAX_COUNT);
    localparam logic [16:0]   MAX_M1  = 17'(MAX_COUNT - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] PAUSED  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [16:0]   count_reg, count_next;
    logic [16:0]   lap_reg, lap_reg_next;
    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic          lap_active_reg, lap_active_next;
    logic          overflow_reg, overflow_next;
    logic          running_reg;
    logic [16:0]   binary_time_reg;
    logic          tick;

`ifdef CORE_TIME_COUNTDOWN_EN
    logic          down_reg, down_next;
    logic          expired_reg, expired_next;
    logic [16:0]   load_clamped;
    assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
`else
    logic          unused_inputs;
    assign unused_inputs = ^{load, load_value};
`endif

    assign tick = (state_reg == RUNNING) && (prescaler_reg == DIV_M1);

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        lap_reg_next    = lap_reg;
        prescaler_next  = prescaler_reg;
        lap_active_next = lap_active_reg;
        overflow_next   = overflow_reg;
`ifdef CORE_TIME_COUNTDOWN_EN
        down_next       = down_reg;
        expired_next    = 1'b0;
`endif
        if (clear) begin
            state_next      = IDLE;
            count_next      = '0;
            lap_reg_next    = '0;
            prescaler_next  = '0;
            lap_active_next = 1'b0;
            overflow_next   = 1'b0;
`ifdef CORE_TIME_COUNTDOWN_EN
            down_next       = 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    prescaler_next = '0;
                    if (start_stop) state_next = RUNNING;
`ifdef CORE_TIME_COUNTDOWN_EN
                    if (load) begin
                        count_next = load_clamped;
                        down_next  = 1'b1;
                        state_next = PAUSED;
                    end
`endif
                end
                RUNNING: begin
                    prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
                    // Lap captures the pre-increment count even when a tick lands on the same edge.
                    if (lap) begin
                        lap_active_next = ~lap_active_reg;
                        if (!lap_active_reg) lap_reg_next = count_reg;
                    end
                    if (start_stop) state_next = PAUSED;
                    if (tick) begin
`ifdef CORE_TIME_COUNTDOWN_EN
                        if (down_reg) begin
                            if (count_reg <= 17'd1) begin
                                count_next      = '0;
                                state_next      = DONE;
                                expired_next    = 1'b1;
                                lap_active_next = 1'b0;
                            end else begin
                                count_next = count_reg - 17'd1;
                            end
                        end else
`endif
                        if (count_reg >= MAX_M1) begin
                            count_next      = MAX_VAL;
                            state_next      = DONE;
                            overflow_next   = 1'b1;
                            lap_active_next = 1'b0;
                        end else begin
                            count_next = count_reg + 17'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (lap) begin
                        lap_active_next = ~lap_active_reg;
                        if (!lap_active_reg) lap_reg_next = count_reg;
                    end
                    if (start_stop) state_next = RUNNING;
`ifdef CORE_TIME_COUNTDOWN_EN
                    if (load) begin
                        count_next     = load_clamped;
                        down_next      = 1'b1;
                        prescaler_next = '0;
                        state_next     = PAUSED;
                    end
`endif
                end
                DONE: begin
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            lap_reg         <= '0;
            prescaler_reg   <= '0;
            lap_active_reg  <= 1'b0;
            overflow_reg    <= 1'b0;
            running_reg     <= 1'b0;
            binary_time_reg <= '0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            lap_reg         <= lap_reg_next;
            prescaler_reg   <= prescaler_next;
            lap_active_reg  <= lap_active_next;
            overflow_reg    <= overflow_next;
            running_reg     <= (state_next == RUNNING);
            binary_time_reg <= lap_active_next ? lap_reg_next : count_next;
        end
    end

`ifdef CORE_TIME_COUNTDOWN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_reg    <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            down_reg    <= down_next;
            expired_reg <= expired_next;
        end
    end
    assign expired = expired_reg;
`else
    assign expired = 1'b0;
`endif

    assign binary_time = binary_time_reg;
    assign running     = running_reg;
    assign lap_active  = lap_active_reg;
    assign overflow    = overflow_reg;
endmodule

// File: tb/tb_core_time_counter.sv
// Bench for core_time_counter: directed scenarios plus random pulses against an
// elapsed-cycles model (count = running cycles / DIV, saturated or counted down).
module tb_core_time_counter;
    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int MAX_COUNT = 20;
    localparam int DIV       = CLK_HZ / TICK_HZ;
`ifdef CORE_TIME_COUNTDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        load;
    logic [16:0] load_value;
    logic [16:0] binary_time;
    logic        running;
    logic        lap_active;
    logic        overflow;
    logic        expired;

    int total = 0;
    int bad   = 0;

    core_time_counter #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .load       (load),
        .load_value (load_value),
        .binary_time(binary_time),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 running, 2 paused, 3 done
    int m_state, m_cycles, m_lap_val, m_load;
    bit m_lap_on, m_ovf, m_exp, m_down;

    function automatic int m_count();
        int t;
        t = m_cycles / DIV;
        if (m_down) return m_load - ((t < m_load) ? t : m_load);
        return (t > MAX_COUNT) ? MAX_COUNT : t;
    endfunction

    task automatic m_reset();
        m_state = 0; m_cycles = 0; m_lap_val = 0; m_load = 0;
        m_lap_on = 0; m_ovf = 0; m_exp = 0; m_down = 0;
    endtask

    task automatic m_toggle_lap(input int pre);
        if (!m_lap_on) begin
            m_lap_on  = 1;
            m_lap_val = pre;
        end else begin
            m_lap_on = 0;
        end
    endtask

    task automatic m_step(input bit ss, input bit cl, input bit lp, input bit ld, input int lv);
        int pre, goal;
        m_exp = 0;
        if (cl) begin
            m_reset();
            return;
        end
        pre = m_count();
        case (m_state)
            0: begin
                if (ld && CD_EN) begin
                    m_load = (lv > MAX_COUNT) ? MAX_COUNT : lv;
                    m_down = 1; m_cycles = 0; m_state = 2;
                end else if (ss) begin
                    m_state = 1;
                end
            end
            1: begin
                m_cycles++;
                goal = m_down ? ((m_load < 1) ? 1 : m_load) : MAX_COUNT;
                if (m_cycles / DIV >= goal) begin
                    m_state  = 3;
                    m_lap_on = 0;
                    if (m_down) m_exp = 1;
                    else        m_ovf = 1;
                end else begin
                    if (lp) m_toggle_lap(pre);
                    if (ss) m_state = 2;
                end
            end
            2: begin
                if (lp) m_toggle_lap(pre);
                if (ld && CD_EN) begin
                    m_load = (lv > MAX_COUNT) ? MAX_COUNT : lv;
                    m_down = 1; m_cycles = 0;
                end else if (ss) begin
                    m_state = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("binary_time", binary_time, m_lap_on ? m_lap_val : m_count());
        check("running", running, (m_state == 1) ? 1 : 0);
        check("lap_active", lap_active, m_lap_on);
        check("overflow", overflow, m_ovf);
        check("expired", expired, m_exp);
    endtask

    task automatic cycle(input bit ss, input bit cl, input bit lp, input bit ld, input int lv);
        @(negedge clk);
        start_stop = ss; clear = cl; lap = lp; load = ld; load_value = 17'(lv);
        @(posedge clk);
        #1;
        m_step(ss, cl, lp, ld, lv);
        start_stop = 0; clear = 0; lap = 0; load = 0;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_time"}, binary_time, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_lap"}, lap_active, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_exp"}, expired, 0);
    endtask

    initial begin
        int exp_pulses;
        rst_n = 0; start_stop = 0; clear = 0; lap = 0; load = 0; load_value = '0;
        m_reset();
        #12;
        check_zero("reset");
        @(negedge clk) rst_n = 1;
        $display("txn reset: time=%0d running=%0d", binary_time, running);

        cycle(1, 0, 0, 0, 0);
        run(105);
        check("t1_time", binary_time, 10);
        check("t1_running", running, 1);
        $display("txn run105: time=%0d running=%0d", binary_time, running);

        #2 rst_n = 0;
        #1;
        check_zero("async_rst");
        m_reset();
        @(negedge clk) rst_n = 1;
        $display("txn async reset: time=%0d", binary_time);

        cycle(1, 0, 0, 0, 0);
        run(34);
        cycle(1, 0, 0, 0, 0);
        run(50);
        cycle(1, 0, 0, 0, 0);
        run(6);
        check("pause_frac", binary_time, 4);
        $display("txn pause/resume: time=%0d", binary_time);

        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        run(70);
        cycle(0, 0, 1, 0, 0);
        run(30);
        check("lap_hold", binary_time, 7);
        check("lap_on", lap_active, 1);
        cycle(0, 0, 1, 0, 0);
        check("lap_release", binary_time, 10);
        $display("txn lap: time=%0d lap_active=%0d", binary_time, lap_active);

        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        run(250);
        check("sat_time", binary_time, MAX_COUNT);
        check("sat_ovf", overflow, 1);
        check("sat_running", running, 0);
        cycle(1, 0, 0, 0, 0);
        check("done_ss_time", binary_time, MAX_COUNT);
        check("done_ss_running", running, 0);
        cycle(0, 1, 0, 0, 0);
        check("clr_time", binary_time, 0);
        check("clr_ovf", overflow, 0);
        $display("txn saturate/clear: time=%0d overflow=%0d", binary_time, overflow);

        cycle(1, 0, 0, 0, 0);
        run(55);
        cycle(1, 1, 0, 0, 0);
        check("clr_ss_time", binary_time, 0);
        check("clr_ss_running", running, 0);
        $display("txn clear+start_stop: time=%0d running=%0d", binary_time, running);

`ifdef CORE_TIME_COUNTDOWN_EN
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 3);
        cycle(1, 0, 0, 0, 0);
        exp_pulses = 0;
        repeat (35) begin
            cycle(0, 0, 0, 0, 0);
            if (expired) exp_pulses++;
        end
        check("cd_pulses", exp_pulses, 1);
        check("cd_time", binary_time, 0);
        check("cd_running", running, 0);
        check("cd_ovf", overflow, 0);
        $display("txn countdown: time=%0d pulses=%0d", binary_time, exp_pulses);
`else
        exp_pulses = 0;
`endif

        cycle(0, 1, 0, 0, 0);
        repeat (3000) begin
            cycle(($urandom_range(29) == 0), ($urandom_range(249) == 0),
                  ($urandom_range(39) == 0), ($urandom_range(59) == 0),
                  int'($urandom_range(30)));
        end
        $display("txn random: 3000 cycles, last time=%0d", binary_time);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_time_counter.md
Name: core_time_counter

Overview:
- Stopwatch core: divides the system clock to a 100 Hz tick and accumulates elapsed time in hundredths of a second.
- Drives the 17-bit binary_time bus consumed directly by core_time_decoder, which splits it into minutes/seconds/hundredths for the display.
- Provides start/stop, clear and lap-hold control from debounced single-cycle button pulses.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 100, count rate; one count equals 1/100 s.
- MAX_COUNT, 131071, saturation value for binary_time; must be ≤ 2^17-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_stop  input  1  one-cycle pulse; toggles run/pause.
- clear  input  1  one-cycle pulse; zero count, return to IDLE.
- lap  input  1  one-cycle pulse; toggles lap hold of the displayed value.
- load  input  1  one-cycle pulse; countdown load (optional feature only).
- load_value  input  17  countdown start value (optional feature only).
- binary_time  output  17  displayed time in hundredths, to core_time_decoder.
- running  output  1  high in RUNNING.
- lap_active  output  1  high while lap hold is engaged.
- overflow  output  1  high in DONE after up-count saturation.
- expired  output  1  one-cycle pulse on countdown reaching 0.

Behaviour:
- One clock domain, all state on clk rising edge. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE.
  - count=0, lap_reg=0, prescaler=0.
  - binary_time=0, running=0, lap_active=0, overflow=0, expired=0.
- Prescaler: DIV=CLK_HZ/TICK_HZ, integer division.
  - Counts 0..DIV-1 only in RUNNING.
  - tick asserts internally for the cycle where prescaler==DIV-1; prescaler wraps to 0 on that cycle.
  - Holds its value in PAUSED, so fractional progress is kept on resume.
  - Cleared to 0 in IDLE.
- FSM states: IDLE, RUNNING, PAUSED, DONE.
  - IDLE + start_stop -> RUNNING.
  - RUNNING + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUNNING.
  - RUNNING + tick with count==MAX_COUNT-1 -> count=MAX_COUNT, DONE, overflow=1.
  - DONE: start_stop and lap ignored; only clear exits.
  - Any state + clear -> IDLE.
- Count: on a tick in RUNNING, count increments by 1 (up mode). count is visible on binary_time the cycle after the tick edge, i.e. 1-cycle latency, registered.
- Lap hold:
  - lap in RUNNING or PAUSED toggles lap_active.
  - On engage, lap_reg captures the current count.
  - While lap_active, binary_time=lap_reg and count keeps running internally. Otherwise binary_time=count.
  - Entering DONE releases the hold, so the saturated value is shown.
- Priority and simultaneous events:
  - clear beats start_stop, lap and load.
  - If a tick and start_stop land in the same cycle, the increment is applied and the state changes on the same edge.
  - If lap and a tick land in the same cycle, lap_reg captures the pre-increment count.
- Width: binary_time never exceeds MAX_COUNT and never wraps.
- Reset mid-operation returns immediately to the reset values, regardless of clk.

Optional Feature:
- Macro: CORE_TIME_COUNTDOWN_EN.
- With the macro defined:
  - load in IDLE or PAUSED sets count=load_value (clamped to MAX_COUNT), sets down mode, and enters PAUSED.
  - In down mode each tick decrements count.
  - A tick with count==1 sets count=0, enters DONE and pulses expired for exactly 1 cycle; overflow stays 0.
  - load_value=0 loads 0; the first tick in RUNNING then enters DONE with an expired pulse.
  - clear returns to up mode.
- Without the macro: load and load_value are ignored, expired is tied 0, and the block is up-count only.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset, then start_stop pulse, run 105 cycles -> binary_time=10, running=1. Assert rst_n=0 mid-count -> all outputs 0 immediately.
- Run to count 3 plus 4 cycles, start_stop, wait 50 cycles, start_stop, then 6 more cycles -> binary_time=4 (fraction kept across the pause).
- At count 7 pulse lap, run 30 cycles -> binary_time=7, lap_active=1. Pulse lap again -> binary_time=10.
- With MAX_COUNT=20, run 250 cycles -> binary_time=20, overflow=1, state DONE. start_stop -> no change. clear -> binary_time=0, overflow=0.
- clear and start_stop in the same cycle while RUNNING at count 5 -> IDLE, binary_time=0, running=0.
- CORE_TIME_COUNTDOWN_EN defined: load load_value=3, start_stop, run 30 cycles -> binary_time=0, exactly one expired pulse, DONE.
